// File: rtl/bin_iir_folder.sv
// Snapshots DFT bin magnitudes, smooths each bin with a first-order IIR (alpha = 2^-SHIFT),
// then folds the smoothed octaves into BPO pitch-class sums, one bin per cycle throughout.
module bin_iir_folder #(
    parameter int BPO   = 24,
    parameter int OC    = 5,
    parameter int N     = 16,
    parameter int ND    = (N * 2) + (OC - 1),
    parameter int SHIFT = 2,
    parameter int NF    = ND + $clog2(OC)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BPO*OC-1:0][ND-1:0]    inBins,
    input  logic                         start,
    input  logic                         clear,
    output logic [BPO-1:0][NF-1:0]       outFolded,
    output logic                         outValid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int NB = BPO * OC;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int BW = (BPO > 1) ? $clog2(BPO) : 1;

    typedef enum logic [1:0] {IDLE, FILTER, FOLD, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   b_q, b_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;

    logic [ND-1:0]   snap_q [NB];
    logic [ND-1:0]   y_q    [NB];
    logic [NF-1:0]   fold_q [BPO];

    // Filter datapath: difference is one bit wider and signed so the shift floors toward -inf.
    logic signed [ND:0] diff;
    logic signed [ND:0] step;
    logic signed [ND:0] y_sum;
    logic [ND-1:0]      y_new;

    always_comb begin
        diff  = $signed({1'b0, snap_q[idx_q]}) - $signed({1'b0, y_q[idx_q]});
        step  = diff >>> SHIFT;
        y_sum = $signed({1'b0, y_q[idx_q]}) + step;
        y_new = y_sum[ND-1:0];
    end

    logic [NF-1:0] fold_term [OC];
    logic [NF-1:0] fold_sum;

    generate
        for (genvar gi = 0; gi < OC; gi++) begin : g_fold_term
            assign fold_term[gi] = NF'(y_q[IW'(gi * BPO) + IW'(b_q)]);
        end
    endgenerate

    always_comb begin
        fold_sum = '0;
        for (int o = 0; o < OC; o++) begin
            fold_sum = fold_sum + fold_term[o];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        b_d       = b_q;
        overrun_d = overrun_q;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FILTER;
                        idx_d   = '0;
                    end
                end
                FILTER: begin
                    if (idx_q == IW'(NB - 1)) begin
                        state_d = FOLD;
                        b_d     = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                FOLD: begin
                    if (b_q == BW'(BPO - 1)) begin
                        state_d = DONE;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
            // Starts are not queued; a start landing in any non-idle state only flags overrun.
            if (start && (state_q != IDLE)) begin
                overrun_d = 1'b1;
            end
        end
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                snap_q[i] <= '0;
                y_q[i]    <= '0;
            end
            for (int i = 0; i < BPO; i++) begin
                fold_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NB; i++) begin
                y_q[i] <= '0;
            end
            for (int i = 0; i < BPO; i++) begin
                fold_q[i] <= '0;
            end
        end else begin
            if ((state_q == IDLE) && start) begin
                for (int i = 0; i < NB; i++) begin
                    snap_q[i] <= inBins[i];
                end
            end
            if (state_q == FILTER) begin
                y_q[idx_q] <= y_new;
            end
            if (state_q == FOLD) begin
                fold_q[b_q] <= fold_sum;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BPO; gi++) begin : g_out
            assign outFolded[gi] = fold_q[gi];
        end
    endgenerate

    assign outValid = valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_bin_iir_folder.sv
// Directed bench: one instance with SHIFT=2 (smoothing, overrun, clear) and one with SHIFT=0
// (folding, snapshot isolation, full-width sums, asynchronous reset mid-pass).
module tb_bin_iir_folder;

    localparam int BPO = 24;
    localparam int OC  = 5;
    localparam int ND  = 36;
    localparam int NF  = 39;
    localparam int NB  = BPO * OC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst2, start2, clear2, valid2, busy2, ovr2;
    logic [NB-1:0][ND-1:0]    bins2;
    logic [BPO-1:0][NF-1:0]   fold2;
    logic                     rst0, start0, clear0, valid0, busy0, ovr0;
    logic [NB-1:0][ND-1:0]    bins0;
    logic [BPO-1:0][NF-1:0]   fold0;

    bin_iir_folder #(.BPO(BPO), .OC(OC), .N(16), .ND(ND), .SHIFT(2), .NF(NF)) dut2 (
        .clk(clk), .rst(rst2), .inBins(bins2), .start(start2), .clear(clear2),
        .outFolded(fold2), .outValid(valid2), .busy(busy2), .overrun(ovr2)
    );

    bin_iir_folder #(.BPO(BPO), .OC(OC), .N(16), .ND(ND), .SHIFT(0), .NF(NF)) dut0 (
        .clk(clk), .rst(rst0), .inBins(bins0), .start(start0), .clear(clear0),
        .outFolded(fold0), .outValid(valid0), .busy(busy0), .overrun(ovr0)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fold2(input string tag, input longint exp);
        for (int b = 0; b < BPO; b++) check(tag, 64'(fold2[b]), exp);
    endtask

    task automatic check_fold0(input string tag, input longint exp);
        for (int b = 0; b < BPO; b++) check(tag, 64'(fold0[b]), exp);
    endtask

    // One pass on the SHIFT=2 instance; j counts edges after the accepting edge.
    task automatic pass2(input int inj, input int clr, output int fv, output int nv);
        fv = -1;
        nv = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("busy_after_start2", 64'(busy2), 64'd1);
        for (int j = 1; j <= 150; j++) begin
            tick();
            if (valid2) begin
                nv++;
                if (fv < 0) fv = j;
            end
            if (j == inj - 1) start2 = 1'b1;
            if (j == inj) begin
                start2 = 1'b0;
                check("overrun_set", 64'(ovr2), 64'd1);
            end
            if (j == clr - 1) clear2 = 1'b1;
            if (j == clr) begin
                clear2 = 1'b0;
                check("clear_busy", 64'(busy2), 64'd0);
                check("clear_fold0", 64'(fold2[0]), 64'd0);
                check("clear_fold23", 64'(fold2[BPO-1]), 64'd0);
                check("clear_ovr_kept", 64'(ovr2), 64'd1);
            end
        end
        $display("pass2: first outValid at edge +%0d, %0d pulses, fold[0]=%0d", fv, nv, fold2[0]);
    endtask

    // One pass on the SHIFT=0 instance, optionally rewriting inBins mid-FILTER or resetting mid-FOLD.
    task automatic pass0(input int mut_at, input int rst_at, output int fv, output int nv);
        fv = -1;
        nv = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("busy_after_start0", 64'(busy0), 64'd1);
        for (int j = 1; j <= 150; j++) begin
            tick();
            if (valid0) begin
                nv++;
                if (fv < 0) fv = j;
            end
            if (j == mut_at) begin
                for (int i = 0; i < NB; i++) bins0[i] = 36'd7 + 36'(i);
            end
            if (j == rst_at) begin
                #3;
                rst0 = 1'b0;
                #1;
                check("arst_fold0", 64'(fold0[0]), 64'd0);
                check("arst_fold23", 64'(fold0[BPO-1]), 64'd0);
                check("arst_busy", 64'(busy0), 64'd0);
                check("arst_valid", 64'(valid0), 64'd0);
            end
            if (j == rst_at + 2) rst0 = 1'b1;
        end
        $display("pass0: first outValid at edge +%0d, %0d pulses, fold[0]=%0d", fv, nv, fold0[0]);
    endtask

    initial begin
        int fv, nv;
        longint ym;
        rst2 = 1'b0; start2 = 1'b0; clear2 = 1'b0; bins2 = '0;
        rst0 = 1'b0; start0 = 1'b0; clear0 = 1'b0; bins0 = '0;
        repeat (3) tick();
        rst2 = 1'b1;
        rst0 = 1'b1;
        tick();

        // Reset state, then a long idle stretch with no change.
        check("rst_valid", 64'(valid2), 64'd0);
        check("rst_busy", 64'(busy2), 64'd0);
        check("rst_ovr", 64'(ovr2), 64'd0);
        check_fold2("rst_fold", 0);
        for (int c = 0; c < 200; c++) begin
            tick();
            check("idle_hold", {60'd0, valid2, busy2, ovr2, (fold2 != '0)}, 64'd0);
        end

        // SHIFT=2, constant 1000: 250 per bin after one pass, 437 after two.
        for (int i = 0; i < NB; i++) bins2[i] = 36'd1000;
        pass2(-10, -10, fv, nv);
        check("lat_first", 64'(fv), 64'd144);
        check("lat_count", 64'(nv), 64'd1);
        check_fold2("fold_1250", 1250);
        check("idle_after", 64'(busy2), 64'd0);
        pass2(-10, -10, fv, nv);
        check_fold2("fold_2185", 2185);

        // Decay to zero: floor shift lets y reach 0 exactly.
        for (int i = 0; i < NB; i++) bins2[i] = '0;
        ym = 437;
        for (int p = 0; p < 40 && ym != 0; p++) begin
            ym = ym + ((64'sd0 - ym) >>> 2);
            pass2(-10, -10, fv, nv);
            check("decay_fold", 64'(fold2[p % BPO]), 64'(5 * ym));
        end
        check("decay_zero", 64'(fold2[0]), 64'd0);

        // Start during a pass is ignored but flags overrun.
        for (int i = 0; i < NB; i++) bins2[i] = 36'd1000;
        pass2(50, -10, fv, nv);
        check("ovr_lat", 64'(fv), 64'd144);
        check("ovr_count", 64'(nv), 64'd1);
        check_fold2("ovr_fold", 1250);
        // Clear aborts the next pass and zeroes state; overrun is sticky.
        pass2(-10, 60, fv, nv);
        check("clr_novalid", 64'(nv), 64'd0);
        check_fold2("clr_fold", 0);
        check("clr_ovr", 64'(ovr2), 64'd1);
        pass2(-10, -10, fv, nv);
        check_fold2("clr_y_zeroed", 1250);

        // Clear and start together: clear wins, no pass and no overrun.
        clear0 = 1'b1;
        start0 = 1'b1;
        tick();
        clear0 = 1'b0;
        start0 = 1'b0;
        check("cs_busy", 64'(busy0), 64'd0);
        check("cs_ovr", 64'(ovr0), 64'd0);

        // SHIFT=0 folding of distinct bins, inputs rewritten mid-FILTER.
        for (int o = 0; o < OC; o++)
            for (int b = 0; b < BPO; b++) bins0[o*BPO + b] = 36'((o + 1) * 4);
        pass0(10, -10, fv, nv);
        check("p0_lat", 64'(fv), 64'd144);
        check_fold0("fold_60", 60);

        // Full-width inputs: sum needs the extra output bits.
        for (int i = 0; i < NB; i++) bins0[i] = {ND{1'b1}};
        pass0(-10, -10, fv, nv);
        check_fold0("fold_max", 64'd343597383675);
        pass0(-10, 130, fv, nv);
        check("arst_novalid", 64'(nv), 64'd0);
        check("arst_ovr", 64'(ovr0), 64'd0);
        check_fold0("arst_fold_after", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_iir_folder.md
Name: bin_iir_folder

Overview:
- Downstream consumer of the DFT bin magnitudes (`outBins`, BPO*OC entries of ND bits).
- On each start pulse it:
  - snapshots all bins;
  - runs a per-bin first-order IIR smoother, one bin per cycle;
  - folds the smoothed octaves into BPO pitch-class bins by summing the same bin index across all octaves.
- Output feeds note-finding and display logic; it implements the DFT's pending IIR stage.

Parameters:
- BPO, 24, bins per octave
- OC, 5, octave count
- N, 16, system sample precision
- ND, (N*2)+(OC-1), input bin magnitude width
- SHIFT, 2, IIR coefficient exponent (alpha = 2^-SHIFT); 0 gives passthrough
- NF, ND+$clog2(OC), folded output width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- inBins  in  ND x (BPO*OC), unsigned  DFT magnitudes; index o*BPO+b
- start  in  1  one-cycle pulse: new bin set complete, begin processing
- clear  in  1  synchronous: zero all IIR state and outputs, abort any pass
- outFolded  out  NF x BPO, unsigned  folded smoothed bins
- outValid  out  1  one-cycle pulse: outFolded updated
- busy  out  1  high while a pass is in progress
- overrun  out  1  sticky: a start arrived while busy

Behaviour:
- Reset (rst low, async): state=IDLE; all filtered state 0; outFolded all 0; outValid=0; busy=0; overrun=0; counters 0.
- States: IDLE, FILTER, FOLD, DONE.
- IDLE:
  - start=1 and clear=0: latch all inBins into the snapshot array and go to FILTER with idx=0.
- FILTER:
  - Each cycle: y[idx] <= y[idx] + ((snap[idx] - y[idx]) >>> SHIFT).
  - The difference is signed ND+1 bits; the shift is arithmetic (floor).
  - The result always lies in [0, 2^ND-1]; no saturation is needed.
  - idx increments each cycle. At idx==BPO*OC-1, go to FOLD with b=0.
  - Exactly BPO*OC cycles.
- FOLD:
  - Each cycle: outFolded[b] <= sum over o=0..OC-1 of y[o*BPO+b], zero-extended to NF bits, no overflow possible.
  - At b==BPO-1, go to DONE. Exactly BPO cycles.
  - outFolded entries update individually during FOLD; consumers read only after outValid.
- DONE:
  - outValid=1 for this single cycle, then IDLE. A start during DONE counts as busy.
- Latency: start sampled at edge k. FILTER occupies cycles k+1..k+BPO*OC, FOLD the next BPO, and outValid is high in cycle k+BPO*OC+BPO+1. Defaults: 145 cycles after the start edge.
- busy is registered: high in FILTER, FOLD and DONE; low in IDLE. It is high the cycle after start is accepted.
- Start while busy:
  - ignored, with no queueing;
  - overrun <= 1 and stays 1 until reset.
  - The pass in progress is unaffected.
- clear, in any state:
  - next edge: y all 0, outFolded all 0, state IDLE, outValid 0;
  - overrun is unchanged.
  - clear and start in the same cycle: clear wins and start is discarded (no overrun).
- Smoother steady state: on rising input, y settles up to 2^SHIFT-1 below x (floor truncation). On falling input, y reaches x exactly. This is intended.
- Reset asserted mid-pass: immediate return to reset values; no outValid.
- inBins may change freely after the start cycle; only the snapshot is used.

Test Plan:
1. Reset only: all outFolded=0, outValid=0, busy=0, overrun=0; hold 200 cycles idle and verify no change.
2. SHIFT=2, all inBins=1000, pulse start at edge k:
   - busy=1 from k+1; outValid only in cycle k+145;
   - every y=250 and outFolded[b]=1250.
   - A second start (same inputs) gives y=437 (250+floor(750/4)) and outFolded=2185.
3. Decay from test 2's state with all inBins=0 and start: y=437+floor(-437/4)=327 and outFolded=1635. Repeated passes reach 0 exactly.
4. Distinct bins: set inBins[o*24+b]=(o+1)*4 with SHIFT=0. One pass gives outFolded[b]=60 for all b; changing inBins during FILTER leaves the result unchanged.
5. Start pulsed at cycle k+50 during a pass: ignored, overrun=1, one outValid only at k+145. Then clear at k+60: all outputs 0, busy=0 at k+61, no outValid, overrun stays 1.
6. Width check: SHIFT=0, all inBins=2^36-1. outFolded=5*(2^36-1) with no wrap. Async rst low mid-FOLD: outputs clear immediately with no clock edge.
